// File: rtl/conv1d_seq_ctrl.sv
// Sequencing controller for the 1D-convolution systolic array: taps, sample injection, tail padding, result stream.
// Optional feature: define CONV1D_FULL_OUTPUT_EN to also return the NUM_TAPS-1 tail results (full convolution).
module conv1d_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_TAPS   = 4,
  parameter int LATENCY    = 9,
  parameter int LEN_W      = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [LEN_W-1:0]               len_in,
  output logic                           busy,
  output logic                           done,
  input  logic                           tap_wr,
  input  logic [$clog2(NUM_TAPS)-1:0]    tap_addr,
  input  logic [DATA_WIDTH-1:0]          tap_data,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] h_flat,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  output logic                           arr_enable,
  output logic                           arr_valid,
  output logic [DATA_WIDTH-1:0]          arr_x,
  input  logic [DATA_WIDTH-1:0]          arr_y,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data
);

  localparam int CNT_W     = LEN_W + 1;
  localparam int PAD_TOTAL = NUM_TAPS - 1 + LATENCY;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAD,
    DONE
  } state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      samp_cnt;
  logic [CNT_W-1:0]      pad_cnt;
  logic [LATENCY-1:0]    tag_pipe;
  logic [DATA_WIDTH-1:0] taps [NUM_TAPS];
  logic                  stall;
  logic                  adv;
  logic                  tag_in;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    stall     = m_valid & ~m_ready;
    adv       = 1'b0;
    s_ready   = 1'b0;
    arr_valid = 1'b0;
    arr_x     = '0;
    tag_in    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len_in == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        s_ready   = ~stall;
        adv       = ~stall & s_valid;
        arr_valid = adv;
        arr_x     = s_data;
        tag_in    = 1'b1;
        if (adv && samp_cnt == CNT_W'(1)) begin
          state_nx = PAD;
        end
      end
      PAD: begin
        adv = ~stall;
`ifdef CONV1D_FULL_OUTPUT_EN
        // The first NUM_TAPS-1 pads carry the tail of the full convolution.
        tag_in = (pad_cnt > CNT_W'(LATENCY));
`else
        tag_in = 1'b0;
`endif
        if (adv && pad_cnt == CNT_W'(1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!m_valid) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign arr_enable = adv;

  // NOTE: the tap bank is reset element by element because h_flat must read
  // zero straight out of reset, unlike a plain storage RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        taps[i] <= '0;
      end
    end else if (state == IDLE && tap_wr && (int'(tap_addr) < NUM_TAPS)) begin
      taps[tap_addr] <= tap_data;
    end
  end

  always_comb begin
    h_flat = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      h_flat[i*DATA_WIDTH +: DATA_WIDTH] = taps[i];
    end
  end

  // Counters, tag pipe and the result register all advance with the array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      samp_cnt <= '0;
      pad_cnt  <= '0;
      tag_pipe <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE) && !m_valid;

      if (state == IDLE && start) begin
        samp_cnt <= CNT_W'(len_in);
      end else if (state == RUN && adv) begin
        samp_cnt <= samp_cnt - CNT_W'(1);
      end

      if (state == RUN && adv && samp_cnt == CNT_W'(1)) begin
        pad_cnt <= CNT_W'(PAD_TOTAL);
      end else if (state == PAD && adv) begin
        pad_cnt <= pad_cnt - CNT_W'(1);
      end

      if (adv) begin
        tag_pipe <= LATENCY'({tag_pipe, tag_in});
      end

      // Tail tag marks the injection whose result sits on arr_y right now.
      if (adv && tag_pipe[LATENCY-1]) begin
        m_valid <= 1'b1;
        m_data  <= arr_y;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
// Self-checking bench for conv1d_seq_ctrl: behavioural array model, randomized jobs, convolution reference.
// Build with or without CONV1D_FULL_OUTPUT_EN to match the RTL configuration.
module tb_conv1d_seq_ctrl;

  localparam int DW  = 8;
  localparam int NT  = 4;
  localparam int LAT = 9;
  localparam int LW  = 8;
  localparam int AW  = $clog2(NT);
`ifdef CONV1D_FULL_OUTPUT_EN
  localparam int EXTRA = NT - 1;
  localparam int FULL  = 1;
`else
  localparam int EXTRA = 0;
  localparam int FULL  = 0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [LW-1:0]  len_in;
  logic           busy;
  logic           done;
  logic           tap_wr;
  logic [AW-1:0]  tap_addr;
  logic [DW-1:0]  tap_data;
  logic [NT*DW-1:0] h_flat;
  logic           s_valid;
  logic           s_ready;
  logic [DW-1:0]  s_data;
  logic           arr_enable;
  logic           arr_valid;
  logic [DW-1:0]  arr_x;
  logic [DW-1:0]  arr_y;
  logic           m_valid;
  logic           m_ready;
  logic [DW-1:0]  m_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] tb_taps [NT];

  conv1d_seq_ctrl #(
    .DATA_WIDTH(DW), .NUM_TAPS(NT), .LATENCY(LAT), .LEN_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len_in(len_in), .busy(busy), .done(done),
    .tap_wr(tap_wr), .tap_addr(tap_addr), .tap_data(tap_data), .h_flat(h_flat),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .arr_enable(arr_enable), .arr_valid(arr_valid), .arr_x(arr_x), .arr_y(arr_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  // Systolic array stand-in: records every injection and presents y[n-LAT] on arr_y.
  logic [DW-1:0] hist [512];
  int inj_cnt = 0;

  always @(posedge clk) begin
    if (!busy) inj_cnt <= 0;
    else if (arr_enable && inj_cnt < 512) begin
      hist[inj_cnt] <= arr_x;
      inj_cnt       <= inj_cnt + 1;
    end
  end

  function automatic logic [DW-1:0] array_out(input int n);
    int k;
    int acc;
    k = n - LAT;
    if (k < 0) return 8'hA5;
    acc = 0;
    for (int i = 0; i < NT; i++) begin
      if (k - i >= 0) acc += int'(h_flat[i*DW +: DW]) * int'(hist[k-i]);
    end
    return DW'(acc);
  endfunction

  always @(negedge clk) arr_y <= array_out(inj_cnt);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic write_tap(input int idx, input logic [DW-1:0] val);
    @(posedge clk); #1;
    tap_wr   = 1'b1;
    tap_addr = AW'(idx);
    tap_data = val;
    @(posedge clk); #1;
    tap_wr = 1'b0;
    @(negedge clk);
    tb_taps[idx] = val;
    check("tap_vis", h_flat[idx*DW +: DW], val);
  endtask

  task automatic run_job(input int len, input bit ones, input bit alt, input int sv_pct,
                         input int mr_pct, input int stall_at, input bit disturb, input bit timed);
    logic [DW-1:0] samples[$];
    logic [DW-1:0] expq[$];
    logic [NT*DW-1:0] exp_h;
    logic [DW-1:0] held;
    int n_res, total, ridx, s_idx, cyc, adv_cnt, done_cyc, stall_cnt, acc;
    bit last_fire, prev_stall, s_fire, stl, exp_en, got_done;

    for (int j = 0; j < len; j++) samples.push_back(ones ? DW'(1) : DW'($urandom));
    n_res = (len == 0) ? 0 : len + EXTRA;
    total = (len == 0) ? 0 : len + NT - 1 + LAT;
    for (int k = 0; k < n_res; k++) begin
      acc = 0;
      for (int i = 0; i < NT; i++)
        if (k - i >= 0 && k - i < len) acc += int'(tb_taps[i]) * int'(samples[k-i]);
      expq.push_back(DW'(acc));
    end

    ridx = 0; s_idx = 0; cyc = 0; adv_cnt = 0; done_cyc = -1; stall_cnt = 0;
    last_fire = 1'b0; prev_stall = 1'b0; held = '0; got_done = 1'b0;

    @(posedge clk); #1;
    start = 1'b1; len_in = LW'(len); s_valid = 1'b0; m_ready = 1'b1;

    while (!got_done) begin
      @(posedge clk); #1;
      start  = 1'b0;
      tap_wr = 1'b0;
      if (disturb && cyc == 2) begin
        start = 1'b1; len_in = LW'(len + 5);
        tap_wr = 1'b1; tap_addr = '0; tap_data = ~tb_taps[0];
      end
      if (!s_valid || last_fire) begin
        s_valid = (s_idx < len) && (alt ? (cyc % 2 == 0) : ($urandom_range(99) < sv_pct));
        if (s_valid) s_data = samples[s_idx];
      end
      if (stall_at >= 0) m_ready = !(cyc >= stall_at && cyc < stall_at + 5);
      else m_ready = ($urandom_range(99) < mr_pct);

      @(negedge clk);
      cyc++;
      s_fire = s_valid && s_ready;
      stl    = m_valid && !m_ready;
      if (stl) stall_cnt++;
      if (s_idx < len) begin
        exp_en = s_fire;
        check("s_ready", s_ready, !stl);
        check("arr_valid", arr_valid, s_fire);
      end else begin
        exp_en = (adv_cnt < total) && !stl;
      end
      check("arr_en", arr_enable, exp_en);
      if (arr_enable) begin
        check("arr_x", arr_x, (s_idx < len) ? s_data : '0);
        adv_cnt++;
      end
      if (prev_stall) begin
        check("hold_v", m_valid, 1'b1);
        check("hold_d", m_data, held);
      end
      if (m_valid && m_ready) begin
        if (ridx < n_res) check("result", m_data, expq[ridx]);
        ridx++;
      end
      if (s_fire) s_idx++;
      last_fire  = s_fire;
      prev_stall = stl;
      held       = m_data;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        check("done_idle", busy, 1'b0);
      end else if (cyc > 3000) begin
        check("timeout", 1'b1, 1'b0);
        got_done = 1'b1;
      end
    end
    s_valid = 1'b0;

    check("n_results", ridx, n_res);
    check("n_adv", adv_cnt, total);
    if (timed) begin
      check("done_cyc", done_cyc, (len == 0) ? 2 : total + 2 + FULL);
      check("no_stall", stall_cnt, 0);
    end
    exp_h = '0;
    for (int i = 0; i < NT; i++) exp_h[i*DW +: DW] = tb_taps[i];
    check("taps_kept", h_flat, exp_h);

    @(posedge clk); #1;
    @(negedge clk);
    check("done_pulse", done, 1'b0);
  endtask

  task automatic reset_in_pad();
    @(posedge clk); #1;
    start = 1'b1; len_in = LW'(3); m_ready = 1'b1; s_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      s_valid = (c < 3);
      s_data  = DW'(c + 1);
      if (c == 10) begin
        @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_mv", m_valid, 1'b1);
      end
      if (c == 11) reset = 1'b0;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_arr_en", arr_enable, 1'b0);
    check("rst_arr_valid", arr_valid, 1'b0);
    check("rst_arr_x", arr_x, '0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, '0);
    check("rst_h_flat", h_flat, '0);
    reset = 1'b1;
    for (int i = 0; i < NT; i++) tb_taps[i] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; len_in = '0; tap_wr = 1'b0; tap_addr = '0; tap_data = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    for (int i = 0; i < NT; i++) tb_taps[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_busy", busy, 1'b0);
    check("init_done", done, 1'b0);
    check("init_s_ready", s_ready, 1'b0);
    check("init_arr_en", arr_enable, 1'b0);
    check("init_m_valid", m_valid, 1'b0);
    check("init_m_data", m_data, '0);
    check("init_h_flat", h_flat, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < NT; i++) write_tap(i, DW'(i + 1));
    run_job(4, 1'b1, 1'b0, 100, 100, -1, 1'b0, 1'b1);
    run_job(16, 1'b0, 1'b0, 100, 100, 12, 1'b0, 1'b0);
    run_job(4, 1'b1, 1'b1, 100, 100, -1, 1'b0, 1'b0);
    run_job(0, 1'b0, 1'b0, 100, 100, -1, 1'b0, 1'b1);
    run_job(6, 1'b0, 1'b0, 100, 100, -1, 1'b1, 1'b0);
    reset_in_pad();

    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < NT; i++) write_tap(i, DW'($urandom));
      run_job($urandom_range(24, 1), 1'b0, 1'b0, $urandom_range(100, 40),
              $urandom_range(100, 40), -1, 1'($urandom_range(1)), 1'b0);
    end
    run_job(20, 1'b0, 1'b0, 100, 100, -1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
